// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encoding and helpers for the UART Tx/Rx paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

`ifdef FORMAL
    localparam int CLOCKS_PER_BIT_DEF = 8;
`else
    localparam int CLOCKS_PER_BIT_DEF = 5000;
`endif

    function automatic int total_bits_in_uart(int data_width, int parity_enabled);
        return data_width + parity_enabled + 2;
    endfunction

    // Callers zero-extend the data word; padding zeros leave the XOR unchanged.
    function automatic logic parity_of(logic [63:0] data, logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int W = 8
);

    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..CLOCKS_PER_BIT-1, pulses tick on terminal count.
module uart_baud_counter #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef FORMAL
    a_cnt_range: assert property (@(posedge clk) int'(cnt) < CLOCKS_PER_BIT);
`endif

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter; start, LSB-first data, optional parity, stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_ODD       = 0,
    parameter int CLOCKS_PER_BIT   = CLOCKS_PER_BIT_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave tx,
    output logic     serial_out,
    output logic     tx_busy,
    output logic     tx_done
);

    localparam int W  = INPUT_DATA_WIDTH;
    localparam int BW = $clog2(W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    uart_state_t   state, state_d;
    logic [W-1:0]  shift, shift_d;
    logic [BW-1:0] bit_idx, bit_d;
    logic          par, par_d;
    logic          line_d;
    logic          done_d;
    logic          tick;

    assign tx.tx_ready = (state == IDLE);
    assign tx_busy     = (state != IDLE);

    uart_baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state == IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            par        <= 1'b0;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            bit_idx    <= bit_d;
            par        <= par_d;
            serial_out <= line_d;
            tx_done    <= done_d;
        end
    end

    // line_d is the level of the next state, so serial_out stays a pure register.
    always_comb begin
        state_d = state;
        shift_d = shift;
        bit_d   = bit_idx;
        par_d   = par;
        line_d  = serial_out;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                line_d = 1'b1;
                if (tx.tx_valid) begin
                    state_d = START;
                    shift_d = tx.tx_data;
                    par_d   = parity_of(64'(tx.tx_data), 1'(PARITY_ODD));
                    line_d  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    line_d  = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        if (PARITY_ENABLED != 0) begin
                            state_d = PARITY;
                            line_d  = par;
                        end else begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        shift_d = shift >> 1;
                        bit_d   = bit_idx + BW'(1);
                        line_d  = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    line_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

`ifdef FORMAL
    a_idle_line: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE) |-> serial_out);
    a_done_stop: assert property (@(posedge clk) disable iff (!rst_n)
        tx_done |-> ($past(state) == STOP));
    a_rdy_fall: assert property (@(posedge clk) disable iff (!rst_n)
        (tx.tx_valid && tx.tx_ready) |=> !tx.tx_ready);
`endif

endmodule
